aes_inv_cipher_core: RTL and testbench
======================================

# aes_inv_cipher_core

Iterative AES inverse cipher with a built-in combinational key expansion, per FIPS-197. It turns a 128-bit ciphertext and a 32·Nk-bit cipher key into the 128-bit plaintext, processing one round per clock. It sits behind the SPI decryption slave, which presents ciphertext and key as static registers and samples the plaintext 54 clocks after the key is loaded.

## Interface
- Nk, 4, key length in 32-bit words; legal values are 4, 6 and 8.
- Nr, 10, number of rounds; must be 10, 12 or 14 to match Nk = 4, 6 or 8.

- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- key  in  32·Nk  cipher key; byte 0 is in the most-significant bits.
- ciphertext  in  128  block to decrypt; byte 0 is bits [127:120].
- round_keys  out  128·(Nr+1)  expanded schedule; word w[0] is in the most-significant 32 bits.
- plaintext  out  128  decrypted block; held until the next completion.
- done  out  1  high while plaintext matches the current inputs.

## Operation
- Key expansion:
  - Purely combinational from key, per FIPS-197 §5.2.
  - Uses RotWord, SubWord and Rcon (01,02,04,08,10,20,40,80,1b,36).
  - For Nk=8, an extra SubWord is applied when i mod Nk = 4.
  - Round key r is words w[4r..4r+3], concatenated MSB-first.
- State byte mapping: byte n = bits [127−8n : 120−8n]; column c holds bytes 4c..4c+3.
- Registers:
  - ct_q and key_q: latched copies of the inputs.
  - state: 128 bits.
  - rnd: 4-bit round counter.
  - start_pend: set by reset.
- FSM has two states, IDLE and RUN.
- Start condition: start_pend=1, or ciphertext≠ct_q, or key≠key_q. Start is evaluated every cycle, in both states.
- Start action:
  - Latch ct_q←ciphertext and key_q←key.
  - Load state ← ciphertext ⊕ roundkey[Nr].
  - Set rnd ← Nr−1, done←0, clear start_pend, go to RUN.
- RUN step (no start pending): state ← InvShiftRows → InvSubBytes → AddRoundKey(roundkey[rnd]) → InvMixColumns.
  - InvMixColumns is skipped when rnd=0.
  - If rnd=0: plaintext ← result, done←1, go to IDLE. Otherwise rnd←rnd−1.
- Round keys are always taken from key_q's expansion, so the schedule is stable during RUN.
- IDLE: hold all outputs.
- Inverse S-box, GF(2⁸) multiplication by 09/0b/0d/0e, and InvShiftRows (row r rotated right by r) follow FIPS-197 exactly.

## Timing
- Reset values: plaintext=0, done=0, state=0, rnd=0, ct_q=0, key_q=0, start_pend=1, FSM=IDLE.
- Latency:
  - Inputs stable before edge k → start at edge k.
  - Plaintext and done=1 after edge k+Nr.
  - Total Nr+1 clocks: 11, 13 or 15, well under the 54-clock budget.
- Input change mid-RUN: restart at that edge, drop done, discard the partial state; plaintext keeps its old value until the new completion.
- Simultaneous input change and the rnd=0 step: the restart wins; plaintext is not updated.
- Reset mid-RUN: return to reset values; a fresh decryption starts on the first edge after reset deasserts.
- round_keys follows key combinationally, with no clock latency.

## Test plan
- AES-128 decryption:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: plaintext 00112233445566778899aabbccddeeff, done high 11 clocks after the inputs settle.
- AES-128 schedule:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: the last 128 bits of round_keys = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Follow-up: ct 3925841d02dc09fbdc118597196a0b32 → plaintext 3243f6a8885a308d313198a2e0370734.
- AES-192 decryption:
  - Stimulus: Nk=6, Nr=12, key 000102…1617, ct dda97ca4864cdfe06eaf70a0ec0d7191.
  - Response: plaintext 00112233445566778899aabbccddeeff after 13 clocks.
- AES-256 decryption:
  - Stimulus: Nk=8, Nr=14, key 000102…1e1f, ct 8ea2b7ca516745bfeafc49904b496089.
  - Response: plaintext 00112233445566778899aabbccddeeff after 15 clocks.
- Restart mid-run:
  - Stimulus: change ct to the §B vector at cycle 5 of a run.
  - Response: done stays 0, old plaintext is held, then the §B plaintext appears 11 clocks after the change.
- Reset:
  - Stimulus: pulse reset mid-run.
  - Response: plaintext=0 and done=0 at the next edge; with the inputs held, the correct plaintext appears 11 clocks after reset deasserts.

Source files
------------

// File: rtl/aes_inv_cipher_core_if.sv
// Ciphertext/key in, expanded schedule and plaintext out, for the iterative
// AES inverse cipher core.
interface aes_inv_cipher_core_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic [32*Nk-1:0]      key;
  logic [127:0]          ciphertext;
  logic [128*(Nr+1)-1:0] round_keys;
  logic [127:0]          plaintext;
  logic                  done;

  modport master (
    output key, ciphertext,
    input  round_keys, plaintext, done
  );

  modport slave (
    input  key, ciphertext,
    output round_keys, plaintext, done
  );
endinterface

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher (one round per clock) with combinational key
// expansion; restarts whenever the ciphertext or key inputs change.
module aes_inv_cipher_core #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_inv_cipher_core_if.slave  cbus
);

  localparam int KW  = 32 * Nk;
  localparam int NW  = 4 * (Nr + 1);
  localparam int RKW = 128 * (Nr + 1);
  localparam logic [3:0] LAST_RND = 4'(Nr - 1);

  localparam logic [2047:0] SBOX_FWD = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  typedef enum logic {IDLE, RUN} fsm_e;

  // Byte b sits at bits [8*(255-b) +: 8] of a table; ~b equals 255-b.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_FWD[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    return SBOX_INV[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1:       rcon = 8'h01;
      2:       rcon = 8'h02;
      3:       rcon = 8'h04;
      4:       rcon = 8'h08;
      5:       rcon = 8'h10;
      6:       rcon = 8'h20;
      7:       rcon = 8'h40;
      8:       rcon = 8'h80;
      9:       rcon = 8'h1b;
      10:      rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
  endfunction

  function automatic logic [RKW-1:0] expand_key(input logic [KW-1:0] k);
    logic [31:0] w [NW];
    logic [31:0] t;
    expand_key = '0;
    for (int i = 0; i < Nk; i++) begin
      w[i] = k[KW-1-32*i -: 32];
    end
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / Nk), 24'h000000};
      else if (Nk > 6 && i % Nk == 4)
        t = sub_word(t);
      w[i] = w[i-Nk] ^ t;
    end
    for (int i = 0; i < NW; i++) begin
      expand_key[RKW-1-32*i -: 32] = w[i];
    end
  endfunction

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round)
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] sr, t, m;
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
      end
    end
    for (int n = 0; n < 16; n++) begin
      t[127-8*n -: 8] = inv_sub_byte(sr[127-8*n -: 8]) ^ rk[127-8*n -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      m[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    end
    return last ? t : m;
  endfunction

  logic [RKW-1:0] rk_all;
  logic [127:0]   rk [Nr+1];
  logic [127:0]   ct_q, ct_d;
  logic [KW-1:0]  key_q, key_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   pt_q, pt_d;
  logic [3:0]     rnd_q, rnd_d;
  logic           start_pend_q, start_pend_d;
  logic           done_q, done_d;
  logic           start;
  logic [127:0]   round_out;
  fsm_e           fsm_q, fsm_d;

  // RUN only advances while key == key_q, so expanding the live key input
  // yields the same schedule as expanding key_q, and one expander serves both.
  assign rk_all          = expand_key(cbus.key);
  assign cbus.round_keys = rk_all;

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk[r] = rk_all[128*(Nr-r) +: 128];
  end

  assign start     = start_pend_q | (cbus.ciphertext != ct_q) | (cbus.key != key_q);
  assign round_out = inv_round(state_q, rk[rnd_q], rnd_q == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    if (start)
      fsm_d = RUN;
    else if (fsm_q == RUN && rnd_q == 4'd0)
      fsm_d = IDLE;
  end

  always_comb begin
    ct_d         = ct_q;
    key_d        = key_q;
    state_d      = state_q;
    pt_d         = pt_q;
    rnd_d        = rnd_q;
    start_pend_d = start_pend_q;
    done_d       = done_q;
    if (start) begin
      ct_d         = cbus.ciphertext;
      key_d        = cbus.key;
      state_d      = cbus.ciphertext ^ rk[Nr];
      rnd_d        = LAST_RND;
      done_d       = 1'b0;
      start_pend_d = 1'b0;
    end else if (fsm_q == RUN) begin
      state_d = round_out;
      if (rnd_q == 4'd0) begin
        pt_d   = round_out;
        done_d = 1'b1;
      end else begin
        rnd_d = rnd_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ct_q         <= '0;
      key_q        <= '0;
      state_q      <= '0;
      pt_q         <= '0;
      rnd_q        <= '0;
      start_pend_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      ct_q         <= ct_d;
      key_q        <= key_d;
      state_q      <= state_d;
      pt_q         <= pt_d;
      rnd_q        <= rnd_d;
      start_pend_q <= start_pend_d;
      done_q       <= done_d;
    end
  end

  assign cbus.plaintext = pt_q;
  assign cbus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed FIPS-197 vectors for the AES-128/192/256 inverse cipher core.
module tb_aes_inv_cipher_core;

  localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_STD  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] KEY_192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  aes_inv_cipher_core_if #(.Nk(4), .Nr(10)) bus128 ();
  aes_inv_cipher_core_if #(.Nk(6), .Nr(12)) bus192 ();
  aes_inv_cipher_core_if #(.Nk(8), .Nr(14)) bus256 ();

  aes_inv_cipher_core #(.Nk(4), .Nr(10)) u_dut128 (.clk(clk), .reset(reset), .cbus(bus128));
  aes_inv_cipher_core #(.Nk(6), .Nr(12)) u_dut192 (.clk(clk), .reset(reset), .cbus(bus192));
  aes_inv_cipher_core #(.Nk(8), .Nr(14)) u_dut256 (.clk(clk), .reset(reset), .cbus(bus256));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus128.key        = KEY_A;
    bus128.ciphertext = CT_A;
    bus192.key        = KEY_192;
    bus192.ciphertext = CT_192;
    bus256.key        = KEY_256;
    bus256.ciphertext = CT_256;
    tick(3);
    chk("rst_pt128",   bus128.plaintext, '0);
    chk("rst_done128", {127'd0, bus128.done}, '0);
    chk("rst_pt256",   bus256.plaintext, '0);
    chk("rst_done256", {127'd0, bus256.done}, '0);

    // Latency: start on the first edge after reset, done after Nr more edges
    reset = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick(1);
      case (cyc)
        10: chk("a128_early_done", {127'd0, bus128.done}, '0);
        11: begin
          chk("a128_done", {127'd0, bus128.done}, 128'd1);
          chk("a128_pt",   bus128.plaintext, PT_STD);
        end
        12: chk("a192_early_done", {127'd0, bus192.done}, '0);
        13: begin
          chk("a192_done", {127'd0, bus192.done}, 128'd1);
          chk("a192_pt",   bus192.plaintext, PT_STD);
        end
        14: chk("a256_early_done", {127'd0, bus256.done}, '0);
        15: begin
          chk("a256_done", {127'd0, bus256.done}, 128'd1);
          chk("a256_pt",   bus256.plaintext, PT_STD);
        end
        default: ;
      endcase
    end

    // Key schedule follows the key input combinationally; restart mid-run
    bus128.key        = KEY_B;
    bus128.ciphertext = CT_A;
    #1;
    chk("rk_last",  bus128.round_keys[127:0], RK10_B);
    chk("rk_first", bus128.round_keys[1407:1280], KEY_B);
    tick(1);
    chk("rs_done_drop", {127'd0, bus128.done}, '0);
    chk("rs_pt_hold1",  bus128.plaintext, PT_STD);
    tick(4);
    chk("rs_done_c5",   {127'd0, bus128.done}, '0);
    bus128.ciphertext = CT_B;
    tick(10);
    chk("rs_early_done", {127'd0, bus128.done}, '0);
    chk("rs_pt_hold2",   bus128.plaintext, PT_STD);
    tick(1);
    chk("b_done", {127'd0, bus128.done}, 128'd1);
    chk("b_pt",   bus128.plaintext, PT_B);

    // Input change coinciding with the final round: the restart wins
    bus128.key        = KEY_A;
    bus128.ciphertext = CT_A;
    tick(10);
    chk("race_pre_done", {127'd0, bus128.done}, '0);
    chk("race_pre_pt",   bus128.plaintext, PT_B);
    bus128.ciphertext = CT_B;
    tick(1);
    chk("race_done", {127'd0, bus128.done}, '0);
    chk("race_pt",   bus128.plaintext, PT_B);

    // Reset mid-run, then a fresh decryption with inputs held
    bus128.ciphertext = CT_A;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("mrst_pt128",   bus128.plaintext, '0);
    chk("mrst_done128", {127'd0, bus128.done}, '0);
    chk("mrst_pt192",   bus192.plaintext, '0);
    reset = 1'b0;
    tick(10);
    chk("mrst_early_done", {127'd0, bus128.done}, '0);
    tick(1);
    chk("mrst_done", {127'd0, bus128.done}, 128'd1);
    chk("mrst_pt",   bus128.plaintext, PT_STD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
